// File: rtl/o_feature_store_if.sv
`default_nettype none
// ============================================================================
// Module   : o_feature_store_if
// Purpose  : Command, on-chip buffer read and external write signals of the
//            feature store engine.
// Revision : 1.0
// ============================================================================
interface o_feature_store_if;
    logic         store_enable;
    logic [7:0]   store_type;
    logic [7:0]   src_addr;
    logic [15:0]  dst_addr;
    logic [7:0]   mem_sel;
    logic [7:0]   store_len;
    logic [14:0]  rd_addr;
    logic         rd_en;
    logic [127:0] rd_data;
    logic         o_mem_select;
    logic [15:0]  ext_wr_addr;
    logic [127:0] ext_wr_data;
    logic         ext_wr_en;
    logic         ext_wr_ready;
    logic         busy;
    logic         store_done;

    modport master (
        output store_enable, store_type, src_addr, dst_addr, mem_sel, store_len,
        output rd_data, ext_wr_ready,
        input  rd_addr, rd_en, o_mem_select, ext_wr_addr, ext_wr_data, ext_wr_en,
        input  busy, store_done
    );

    modport slave (
        input  store_enable, store_type, src_addr, dst_addr, mem_sel, store_len,
        input  rd_data, ext_wr_ready,
        output rd_addr, rd_en, o_mem_select, ext_wr_addr, ext_wr_data, ext_wr_en,
        output busy, store_done
    );
endinterface
`default_nettype wire

// File: rtl/o_feature_store.sv
`default_nettype none
// ============================================================================
// Module   : o_feature_store
// Purpose  : Streams a contiguous run of feature-out buffer beats to external
//            memory through a skid FIFO that absorbs the buffer read latency.
// Revision : 1.0
// ============================================================================
module o_feature_store #(
    parameter int RD_LATENCY      = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int OUT_ADDR_OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    o_feature_store_if.slave bus
);
    localparam int              c_pw       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_cw       = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_pw-1:0] c_last_ptr = c_pw'(FIFO_DEPTH - 1);
    localparam logic [15:0]     c_out_off  = 16'(OUT_ADDR_OFFSET);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [7:0]            src_q;
    logic [7:0]            len_q;
    logic [7:0]            rd_issued_q;
    logic [7:0]            wr_count_q;
    logic [7:0]            unused_type_q;
    logic [15:0]           dst_q;
    logic                  mem_sel_q;
    logic                  rd_en_q;
    logic                  busy_q;
    logic                  store_done_q;
    logic [14:0]           rd_addr_q;
    logic [RD_LATENCY-1:0] pipe_q;
    logic [127:0]          fifo_q [FIFO_DEPTH];
    logic [c_pw-1:0]       wr_ptr_q;
    logic [c_pw-1:0]       rd_ptr_q;
    logic [c_cw-1:0]       count_q;
    logic [c_cw-1:0]       count_d;

    logic push;
    logic pop;
    logic can_issue;
    int   claimed;
    logic unused_bits;

    assign push        = pipe_q[RD_LATENCY-1];
    assign pop         = (count_q != '0) && bus.ext_wr_ready;
    assign unused_bits = ^{unused_type_q, bus.mem_sel[7:1]};

    // Every issued read owns a FIFO slot until popped, so a new read is only
    // issued while queued plus outstanding beats leave room for it.
    always_comb begin
        claimed = int'(count_q) + int'(rd_en_q) - int'(pop);
        for (int i = 0; i < RD_LATENCY; i++) begin
            claimed = claimed + int'(pipe_q[i]);
        end
        can_issue = (rd_issued_q < len_q) && (claimed < FIFO_DEPTH);
        count_d   = count_q + c_cw'(push) - c_cw'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            unused_type_q <= '0;
            mem_sel_q     <= 1'b0;
            rd_issued_q   <= '0;
            wr_count_q    <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            busy_q        <= 1'b0;
            store_done_q  <= 1'b0;
            pipe_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pipe_q       <= pipe_q << 1;
            pipe_q[0]    <= rd_en_q;
            count_q      <= count_d;
            rd_en_q      <= 1'b0;
            store_done_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.store_enable) begin
                        src_q         <= bus.src_addr;
                        dst_q         <= bus.dst_addr;
                        len_q         <= bus.store_len;
                        unused_type_q <= bus.store_type;
                        mem_sel_q     <= bus.mem_sel[0];
                        wr_count_q    <= '0;
                        busy_q        <= 1'b1;
                        if (bus.store_len == 8'd0) begin
                            state_q      <= S_DONE;
                            store_done_q <= 1'b1;
                            rd_issued_q  <= '0;
                        end else begin
                            // First read goes out with the accept so it lands in cycle 1.
                            state_q     <= S_RUN;
                            rd_en_q     <= 1'b1;
                            rd_addr_q   <= {7'd0, bus.src_addr};
                            rd_issued_q <= 8'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (can_issue) begin
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= {7'd0, src_q} + {7'd0, rd_issued_q};
                        rd_issued_q <= rd_issued_q + 8'd1;
                    end
                    if (pop) begin
                        wr_count_q <= wr_count_q + 8'd1;
                        if (wr_count_q + 8'd1 == len_q) begin
                            state_q      <= S_DONE;
                            store_done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.o_mem_select = mem_sel_q;
    assign bus.ext_wr_en    = (count_q != '0);
    assign bus.ext_wr_data  = fifo_q[rd_ptr_q];
    assign bus.ext_wr_addr  = (state_q == S_IDLE) ? 16'd0
                            : dst_q + c_out_off + {8'd0, wr_count_q};
    assign bus.busy         = busy_q;
    assign bus.store_done   = store_done_q;
endmodule
`default_nettype wire
